// File: rtl/riscv_pkg.sv
// Shared RV32 constants, fetch-queue entry layout and fetch-state encoding
// used by the instruction fetch unit and its queue.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_FILL  = 2'd0,
    FETCH_FULL  = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC with wrap to 0 once the next word would fall past the end of imem.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] limit);
    logic [XLEN-1:0] sum;
    sum = pc + XLEN'(INSTR_BYTES);
    return (sum >= limit) ? '0 : sum;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: imem read port, redirect request and the decode-side
// valid/ready instruction stream.
interface instruction_fetch_unit_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rd;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            misalign_err;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_valid never depends on instr_ready, and the
  // head stays stable until it transfers or a redirect/reset discards it.
  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output misalign_err
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  misalign_err
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr} entries with push, pop and flush; the head is
// read straight from storage registers so no imem path reaches the outputs.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an empty queue never exposes it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    head = '{pc: '0, instr: NOP_INSTR};
    if (!empty) head = mem[rd_ptr];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads imem combinationally and queues
// {pc, instr} for decode, with stall back-pressure and redirect flush.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
  parameter int              IMEM_BYTES = 32,
  parameter int              DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus,
  output fetch_state_e              state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] LIMIT = XLEN'(IMEM_BYTES);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_target;
  fetch_entry_t    head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            pop;
  logic            fetch_en;
  logic            misalign_q;

  assign pop      = !empty && bus.instr_ready;
  assign fetch_en = !full || pop;

  // Targets outside imem restart at 0; otherwise the low bits are dropped.
  assign redirect_target = (bus.redirect_pc >= LIMIT) ? '0
                         : {bus.redirect_pc[XLEN-1:2], 2'b00};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (fetch_en),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .push_data ('{pc: pc_q, instr: bus.imem_rd}),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) pc_q <= redirect_target;
      else if (fetch_en)      pc_q <= next_pc(pc_q, LIMIT);
    end
  end

  // Observational state: FLUSH marks the single empty cycle after a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH_FILL;
    end else if (bus.redirect_valid) begin
      state <= FETCH_FLUSH;
    end else begin
      case (state)
        FETCH_FLUSH: state <= FETCH_FILL;
        FETCH_FILL:  if (count == CW'(DEPTH) && !pop) state <= FETCH_FULL;
        FETCH_FULL:  if (pop) state <= FETCH_FILL;
        default:     state <= FETCH_FILL;
      endcase
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.instr_valid  = !empty;
  assign bus.instr        = head.instr;
  assign bus.instr_pc     = head.pc;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random ready and
// redirect traffic, checked by a scoreboard against a fetch-stream model.
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int          IMEM_BYTES = 32;
  localparam int          DEPTH      = 2;

  logic         clk;
  logic         reset;
  fetch_state_e state;
  logic [31:0]  imem [8];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_rd = imem[bus.imem_addr[4:2]];

  // ---- scoreboard state ----
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  int          occ;
  logic [31:0] model_pc;
  logic        exp_mis;
  logic        after_redirect;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch stream: consecutive word addresses, wrapping to 0 at the end of imem.
  task automatic refill();
    while (exp_q.size() < DEPTH + 2) begin
      exp_q.push_back({model_pc, imem[model_pc[4:2]]});
      model_pc = (model_pc + 32'd4 >= 32'(IMEM_BYTES)) ? 32'd0 : model_pc + 32'd4;
    end
  endtask

  // ---- monitor: compare mid-cycle, then advance the model across the next edge ----
  always @(negedge clk) begin
    logic        pop_m;
    logic        push_m;
    logic [31:0] tgt;
    if (!reset) begin
      chk("rst_valid", 64'(bus.instr_valid), 64'd0);
      chk("rst_instr", 64'(bus.instr), 64'(NOP_INSTR));
      chk("rst_pc", 64'(bus.instr_pc), 64'd0);
      chk("rst_misalign", 64'(bus.misalign_err), 64'd0);
      chk("rst_addr", 64'(bus.imem_addr), 64'(RESET_PC));
      occ = 0;
      exp_mis = 1'b0;
      after_redirect = 1'b0;
      model_pc = RESET_PC;
      exp_q.delete();
      refill();
    end else begin
      chk("valid", 64'(bus.instr_valid), 64'(occ > 0));
      chk("imem_addr", 64'(bus.imem_addr), 64'(exp_q[occ][63:32]));
      chk("misalign", 64'(bus.misalign_err), 64'(exp_mis));
      if (after_redirect) chk("flush_state", 64'(state), 64'(FETCH_FLUSH));
      if (occ > 0) chk("head", {bus.instr_pc, bus.instr}, exp_q[0]);
      pop_m = (occ > 0) && bus.instr_ready;
      if (pop_m) void'(exp_q.pop_front());
      if (bus.redirect_valid) begin
        tgt = (bus.redirect_pc >= 32'(IMEM_BYTES)) ? 32'd0 : (bus.redirect_pc & ~32'd3);
        exp_q.delete();
        occ = 0;
        model_pc = tgt;
        exp_mis = (bus.redirect_pc[1:0] != 2'b00);
        after_redirect = 1'b1;
      end else begin
        push_m = (occ < DEPTH) || pop_m;
        occ = occ - int'(pop_m) + int'(push_m);
        exp_mis = 1'b0;
        after_redirect = 1'b0;
      end
      refill();
    end
  end

  // ---- driver tasks ----
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input logic ready, input int n);
    bus.instr_ready = ready;
    step(n);
  endtask

  task automatic redirect(input logic [31:0] pc, input logic ready);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    bus.instr_ready    = ready;
    step(1);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    imem[0] = 32'h0094_0333;  // add
    imem[1] = 32'h4139_03b3;  // sub
    imem[2] = 32'h035a_02b3;  // mul
    imem[3] = 32'h017b_4e33;  // xor
    imem[4] = 32'h01cc_1eb3;  // sll
    imem[5] = 32'h01bd_5f33;  // srl
    imem[6] = 32'h01ee_7fb3;  // and
    imem[7] = 32'h00f7_68b3;  // or
    reset = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step(3);
    reset = 1'b1;

    run(1'b1, 12);                 // streaming with wrap past pc 28
    run(1'b0, 6);                  // stall: queue fills, imem_addr freezes
    run(1'b1, 4);
    run(1'b0, 3);
    redirect(32'h14, 1'b0);        // redirect while full
    run(1'b0, 2);
    run(1'b1, 3);
    redirect(32'h0E, 1'b1);        // misaligned target
    run(1'b1, 4);
    run(1'b0, 2);
    reset = 1'b0;                  // asynchronous reset with entries queued
    step(2);
    reset = 1'b1;
    run(1'b1, 4);
    redirect(32'h08, 1'b1);        // redirect on the same edge as a pop
    run(1'b1, 4);
    redirect(32'h10, 1'b1);        // back-to-back redirects
    redirect(32'h19, 1'b0);
    run(1'b1, 3);
    redirect(32'h40, 1'b1);        // out-of-range target
    run(1'b1, 3);

    for (int i = 0; i < 300; i++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        redirect(32'($urandom_range(0, 47)), ($urandom_range(0, 1) == 1));
      end else begin
        step(1);
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
